// File: rtl/pid_ap_sequencer.sv
// Launch sequencer for the HLS PID core (ap_ctrl_hs): periodic/software launch,
// input hold, duty capture on ap_done, watchdog and sticky error reporting.
module pid_ap_sequencer #(
    parameter int DATA_W    = 25,
    parameter int DOUT_W    = 8,
    parameter int PERIOD_W  = 16,
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 cfg_enable,
    input  logic [PERIOD_W-1:0]  cfg_period,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic                 sw_trigger,
    input  logic                 err_clr,
    input  logic [DATA_W-1:0]    din_0_in,
    input  logic [DATA_W-1:0]    din_1_in,
    output logic [DATA_W-1:0]    pid_din_0_V,
    output logic [DATA_W-1:0]    pid_din_1_V,
    output logic                 pid_ap_start,
    input  logic                 pid_ap_ready,
    input  logic                 pid_ap_done,
    input  logic                 pid_ap_idle,
    input  logic [DOUT_W-1:0]    pid_dout_0_V,
    input  logic [DOUT_W-1:0]    pid_dout_1_V,
    output logic [DOUT_W-1:0]    dout_0,
    output logic [DOUT_W-1:0]    dout_1,
    output logic                 busy,
    output logic                 done_pulse,
    output logic                 timeout_err,
    output logic                 overrun_err,
    output logic [CNT_W-1:0]     sample_cnt
);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t               state, state_nxt;
    logic [PERIOD_W-1:0]  per_cnt;
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic [TIMEOUT_W:0]   wd_inc;
    logic                 tick, trig, expire;
    logic                 launch, capture, timeout_set, overrun_set;

    assign tick   = cfg_enable && (cfg_period != '0) && (per_cnt == cfg_period - PERIOD_W'(1));
    assign trig   = tick | sw_trigger;
    // wd_inc is the number of START/WAIT cycles including the current one
    assign wd_inc = {1'b0, wd_cnt} + (TIMEOUT_W+1)'(1);
    assign expire = (cfg_timeout != '0) && (wd_inc == {1'b0, cfg_timeout});
    assign busy   = (state != IDLE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            per_cnt <= '0;
        end else if (!cfg_enable || cfg_period == '0) begin
            per_cnt <= '0;
        end else if (per_cnt >= cfg_period - PERIOD_W'(1)) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + PERIOD_W'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        launch       = 1'b0;
        capture      = 1'b0;
        timeout_set  = 1'b0;
        overrun_set  = 1'b0;
        pid_ap_start = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    if (pid_ap_idle) begin
                        launch    = 1'b1;
                        state_nxt = START;
                    end else begin
                        overrun_set = 1'b1;
                    end
                end
            end
            START: begin
                pid_ap_start = 1'b1;
                overrun_set  = trig;
                if (pid_ap_ready && pid_ap_done) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (expire) begin
                    timeout_set = 1'b1;
                    state_nxt   = IDLE;
                end else if (pid_ap_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                overrun_set = trig;
                // a done coinciding with expiry is still a valid result
                if (pid_ap_done) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (expire) begin
                    timeout_set = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wd_cnt <= '0;
        end else if (launch) begin
            wd_cnt <= '0;
        end else if (state != IDLE) begin
            wd_cnt <= wd_inc[TIMEOUT_W-1:0];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pid_din_0_V <= '0;
            pid_din_1_V <= '0;
        end else if (launch) begin
            pid_din_0_V <= din_0_in;
            pid_din_1_V <= din_1_in;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dout_0     <= '0;
            dout_1     <= '0;
            done_pulse <= 1'b0;
            sample_cnt <= '0;
        end else begin
            done_pulse <= capture;
            if (capture) begin
                dout_0     <= pid_dout_0_V;
                dout_1     <= pid_dout_1_V;
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            timeout_err <= timeout_set | (timeout_err & ~err_clr);
            overrun_err <= overrun_set | (overrun_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_pid_ap_sequencer.sv
// Self-checking bench for pid_ap_sequencer: a scripted PID core plus a
// run-schedule reference model predicting every output cycle by cycle.
module tb_pid_ap_sequencer;

    localparam int DATA_W    = 25;
    localparam int DOUT_W    = 8;
    localparam int PERIOD_W  = 16;
    localparam int TIMEOUT_W = 16;
    localparam int CNT_W     = 16;

    logic                 HCLK = 1'b0;
    logic                 HRESETn = 1'b0;
    logic                 cfg_enable = 1'b0;
    logic [PERIOD_W-1:0]  cfg_period = '0;
    logic [TIMEOUT_W-1:0] cfg_timeout = '0;
    logic                 sw_trigger = 1'b0;
    logic                 err_clr = 1'b0;
    logic [DATA_W-1:0]    din_0_in = '0;
    logic [DATA_W-1:0]    din_1_in = '0;
    logic [DATA_W-1:0]    pid_din_0_V, pid_din_1_V;
    logic                 pid_ap_start;
    logic                 pid_ap_ready = 1'b0;
    logic                 pid_ap_done = 1'b0;
    logic                 pid_ap_idle = 1'b1;
    logic [DOUT_W-1:0]    pid_dout_0_V = '0;
    logic [DOUT_W-1:0]    pid_dout_1_V = '0;
    logic [DOUT_W-1:0]    dout_0, dout_1;
    logic                 busy, done_pulse, timeout_err, overrun_err;
    logic [CNT_W-1:0]     sample_cnt;

    always #5 HCLK = ~HCLK;

    pid_ap_sequencer #(
        .DATA_W(DATA_W), .DOUT_W(DOUT_W), .PERIOD_W(PERIOD_W),
        .TIMEOUT_W(TIMEOUT_W), .CNT_W(CNT_W)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cfg_enable(cfg_enable), .cfg_period(cfg_period), .cfg_timeout(cfg_timeout),
        .sw_trigger(sw_trigger), .err_clr(err_clr),
        .din_0_in(din_0_in), .din_1_in(din_1_in),
        .pid_din_0_V(pid_din_0_V), .pid_din_1_V(pid_din_1_V),
        .pid_ap_start(pid_ap_start), .pid_ap_ready(pid_ap_ready),
        .pid_ap_done(pid_ap_done), .pid_ap_idle(pid_ap_idle),
        .pid_dout_0_V(pid_dout_0_V), .pid_dout_1_V(pid_dout_1_V),
        .dout_0(dout_0), .dout_1(dout_1), .busy(busy), .done_pulse(done_pulse),
        .timeout_err(timeout_err), .overrun_err(overrun_err), .sample_cnt(sample_cnt)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: each launch is turned into a schedule (ready/done/end cycle)
    longint      cyc = 0;
    int unsigned en_age = 0;
    bit          run_active = 0, cap = 0, core_hung = 0;
    longint      t0 = 0, end_c = 0, dcyc = 0;
    int unsigned pr = 0, pd = 0;
    logic [DOUT_W-1:0] pl0 = '0, pl1 = '0;

    bit          fix_plan = 0, fix_never = 0, fix_dout = 0, keep_din = 0;
    int unsigned fix_r = 0, fix_d = 0, rmax = 3, dmax = 6;
    logic [DOUT_W-1:0] fix_o0 = '0;

    logic              e_busy = 0, e_start = 0, e_done = 0, e_to = 0, e_ovr = 0;
    logic [DOUT_W-1:0] e_dout0 = '0, e_dout1 = '0;
    logic [CNT_W-1:0]  e_cnt = '0;
    logic [DATA_W-1:0] e_din0 = '0, e_din1 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy",        32'(busy),         32'(e_busy));
        chk("ap_start",    32'(pid_ap_start), 32'(e_start));
        chk("done_pulse",  32'(done_pulse),   32'(e_done));
        chk("timeout_err", 32'(timeout_err),  32'(e_to));
        chk("overrun_err", 32'(overrun_err),  32'(e_ovr));
        chk("dout_0",      32'(dout_0),       32'(e_dout0));
        chk("dout_1",      32'(dout_1),       32'(e_dout1));
        chk("sample_cnt",  32'(sample_cnt),   32'(e_cnt));
        chk("pid_din_0",   32'(pid_din_0_V),  32'(e_din0));
        chk("pid_din_1",   32'(pid_din_1_V),  32'(e_din1));
    endtask

    task automatic step(input bit sw = 0, input bit clr = 0);
        bit     tick, trig, ending, ovr_set, to_set;
        longint exp_c;
        sw_trigger = sw;
        err_clr    = clr;
        if (!keep_din) begin
            din_0_in = DATA_W'($urandom);
            din_1_in = DATA_W'($urandom);
        end
        tick = cfg_enable && (cfg_period != 0) &&
               ((en_age % cfg_period) == (cfg_period - 1));
        trig = tick || sw;
        pid_ap_ready = run_active && (cyc == t0 + 1 + pr) && (cyc <= end_c);
        pid_ap_done  = run_active && cap && (cyc == dcyc);
        pid_ap_idle  = !core_hung && !run_active;
        pid_dout_0_V = pid_ap_done ? pl0 : DOUT_W'($urandom);
        pid_dout_1_V = pid_ap_done ? pl1 : DOUT_W'($urandom);

        ending  = run_active && (cyc == end_c);
        ovr_set = 0;
        to_set  = 0;
        e_done  = 0;
        if (ending) begin
            if (cap) begin
                e_dout0 = pl0;
                e_dout1 = pl1;
                e_done  = 1;
                e_cnt   = e_cnt + 1'b1;
            end else begin
                to_set    = 1;
                core_hung = 1;
            end
        end
        if (trig) begin
            if (run_active || !pid_ap_idle) begin
                ovr_set = 1;
            end else begin
                t0     = cyc;
                e_din0 = din_0_in;
                e_din1 = din_1_in;
                if (fix_plan) begin pr = fix_r; pd = fix_d; end
                else begin pr = $urandom_range(rmax, 0); pd = $urandom_range(dmax, 0); end
                pl0   = fix_dout ? fix_o0 : DOUT_W'($urandom);
                pl1   = DOUT_W'($urandom);
                exp_c = t0 + longint'(cfg_timeout);
                dcyc  = t0 + 1 + pr + pd;
                if (!fix_never && (cfg_timeout == 0 || dcyc <= exp_c)) begin
                    cap = 1; end_c = dcyc;
                end else begin
                    cap = 0; end_c = exp_c;
                end
                run_active = 1;
                ending     = 0;
            end
        end
        if (ending) run_active = 0;
        e_to    = to_set  | (e_to  & !clr);
        e_ovr   = ovr_set | (e_ovr & !clr);
        e_busy  = run_active;
        e_start = run_active && (cyc + 1 <= t0 + 1 + pr) && (cyc + 1 <= end_c);
        if (cfg_enable) en_age++; else en_age = 0;

        @(posedge HCLK);
        #1;
        cyc++;
        check_all();
        sw_trigger = 0;
        err_clr    = 0;
    endtask

    task automatic run_n(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && run_active; i++) step();
        chk("drain_bound", 32'(run_active), 32'd0);
    endtask

    task automatic async_reset();
        cfg_enable = 0;
        HRESETn = 0;
        #1;
        e_busy = 0; e_start = 0; e_done = 0; e_to = 0; e_ovr = 0;
        e_dout0 = '0; e_dout1 = '0; e_cnt = '0; e_din0 = '0; e_din1 = '0;
        run_active = 0; core_hung = 0; en_age = 0;
        check_all();
        @(negedge HCLK);
        HRESETn = 1;
    endtask

    initial begin
        // reset state
        @(posedge HCLK);
        #1;
        check_all();
        @(negedge HCLK);
        HRESETn = 1;
        run_n(2);

        // single software launch, ready in first START cycle, done three cycles later
        fix_plan = 1; fix_r = 0; fix_d = 3; fix_dout = 1; fix_o0 = 8'h5A;
        keep_din = 1; din_0_in = 25'h0000123; din_1_in = 25'h1ABCDEF;
        step(1);
        keep_din = 0;
        chk("tp1_start", 32'(pid_ap_start), 32'd1);
        chk("tp1_din0",  32'(pid_din_0_V),  32'h123);
        run_n(4);
        chk("tp1_dout0", 32'(dout_0),     32'h5A);
        chk("tp1_pulse", 32'(done_pulse), 32'd1);
        chk("tp1_cnt",   32'(sample_cnt), 32'd1);
        fix_dout = 0;
        run_n(2);

        // periodic launches every 10 cycles
        fix_r = 1; fix_d = 3;
        cfg_period = 10; cfg_enable = 1;
        run_n(50);
        cfg_enable = 0;
        drain();
        chk("per_cnt", 32'(sample_cnt),  32'd6);
        chk("per_ovr", 32'(overrun_err), 32'd0);

        // period shorter than core latency
        fix_r = 0; fix_d = 6;
        cfg_period = 4; cfg_enable = 1;
        run_n(20);
        cfg_enable = 0;
        drain();
        chk("ovr_set", 32'(overrun_err), 32'd1);
        step(0, 1);
        chk("ovr_clr", 32'(overrun_err), 32'd0);

        // watchdog expiry with a core that never finishes, then hung core drops triggers
        cfg_timeout = 8; fix_never = 1;
        step(1);
        run_n(9);
        chk("to_err",  32'(timeout_err), 32'd1);
        chk("to_busy", 32'(busy),        32'd0);
        fix_never = 0;
        step(1);
        core_hung = 0;
        step(0, 1);

        // done exactly at expiry wins, one cycle later loses
        cfg_timeout = 5; fix_r = 1; fix_d = 3;
        step(1); drain(); step();
        fix_d = 4;
        step(1); drain(); step();
        core_hung = 0;
        step(0, 1);

        // ready and done together, then overrun set racing err_clr
        cfg_timeout = 0; fix_r = 0; fix_d = 0;
        step(1); run_n(3);
        fix_d = 4;
        step(1); step(); step(1, 1);
        drain();
        step(0, 1);

        // randomized traffic, with and without watchdog
        fix_plan = 0; cfg_timeout = 7; cfg_period = 6;
        for (int unsigned i = 0; i < 400; i++) begin
            if ($urandom_range(39, 0) == 0) cfg_enable = !cfg_enable;
            if (core_hung && $urandom_range(7, 0) == 0) core_hung = 0;
            step($urandom_range(5, 0) == 0, $urandom_range(24, 0) == 0);
        end
        cfg_enable = 0;
        drain();
        core_hung = 0;
        cfg_timeout = 0; cfg_period = 9;
        for (int unsigned i = 0; i < 200; i++) begin
            if ($urandom_range(29, 0) == 0) cfg_enable = !cfg_enable;
            step($urandom_range(4, 0) == 0, $urandom_range(19, 0) == 0);
        end
        cfg_enable = 0;
        drain();

        // reset while waiting for done, then a clean run
        fix_plan = 1; fix_r = 0; fix_d = 10;
        step(1); run_n(3);
        async_reset();
        run_n(2);
        fix_r = 1; fix_d = 2;
        step(1);
        drain();
        step();
        chk("rst_cnt", 32'(sample_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
